// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code sequencer: turns the receiver's byte stream into make/break
// events and a held-key bitmap for the ten game-control keys. Handles the E0
// and F0 prefixes, swallows the Pause (E1) sequence and abandons a prefix
// that is left waiting too long for its next byte.
module ps2_key_decoder #(
   parameter int TIMEOUT_CYCLES = 2000000,
   parameter int TO_WIDTH       = 21
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       code_valid,
   input  logic [7:0] code_byte,
   output logic [9:0] key_state,
   output logic       ev_valid,
   output logic [3:0] ev_key,
   output logic       ev_pressed,
   output logic       err_timeout
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK,
      S_SKIP
   } state_t;

   localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   // Scan codes per key index; 0-4 are plain codes, 5-9 need the E0 prefix.
   localparam logic [7:0] KEY_CODE [10] = '{
      8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29,
      8'h75, 8'h6B, 8'h72, 8'h74, 8'h5A
   };

   state_t              state_reg, state_next;
   logic [2:0]          skip_reg, skip_next;
   logic [TO_WIDTH-1:0] to_reg, to_next;
   logic [9:0]          key_state_reg, key_state_next;
   logic                ev_valid_reg, ev_valid_next;
   logic [3:0]          ev_key_reg, ev_key_next;
   logic                ev_pressed_reg, ev_pressed_next;
   logic                err_reg, err_next;

   logic                ext_lookup;
   logic [9:0]          hit_vec;
   logic                hit_any;
   logic [3:0]          hit_idx;
   logic                do_make;
   logic                do_break;

   // The final byte is looked up in the extended half of the table only when
   // it follows an E0 prefix.
   assign ext_lookup = (state_reg == S_EXT) || (state_reg == S_EXT_BRK);

   for (genvar gi = 0; gi < 10; gi++) begin : g_match
      localparam logic IS_EXT = (gi >= 5);
      assign hit_vec[gi] = (code_byte == KEY_CODE[gi]) && (ext_lookup == IS_EXT);
   end

   // Encode the (at most one-hot) match vector into a key index.
   always_comb begin
      hit_any = |hit_vec;
      hit_idx = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (hit_vec[i]) hit_idx = 4'(i);
      end
   end

   // Prefix sequencing, timeout, and key bitmap / event generation.
   always_comb begin
      state_next      = state_reg;
      skip_next       = skip_reg;
      to_next         = to_reg;
      key_state_next  = key_state_reg;
      ev_valid_next   = 1'b0;
      ev_key_next     = ev_key_reg;
      ev_pressed_next = ev_pressed_reg;
      err_next        = 1'b0;
      do_make         = 1'b0;
      do_break        = 1'b0;

      if (code_valid) begin
         // A byte always wins over a coinciding timeout expiry.
         to_next = '0;
         case (state_reg)
            S_IDLE: begin
               if (code_byte == 8'hE0)      state_next = S_EXT;
               else if (code_byte == 8'hF0) state_next = S_BRK;
               else if (code_byte == 8'hE1) begin
                  state_next = S_SKIP;
                  skip_next  = 3'd7;
               end
               else if (code_byte == 8'hAA) key_state_next = '0;
               else                         do_make = 1'b1;
            end
            S_EXT: begin
               if (code_byte == 8'hF0)      state_next = S_EXT_BRK;
               else if (code_byte != 8'hE0) begin
                  do_make    = 1'b1;
                  state_next = S_IDLE;
               end
            end
            S_BRK, S_EXT_BRK: begin
               do_break   = 1'b1;
               state_next = S_IDLE;
            end
            S_SKIP: begin
               skip_next = skip_reg - 3'd1;
               if (skip_reg <= 3'd1) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
         endcase
      end
      else if (state_reg != S_IDLE) begin
         if (to_reg == TO_LAST) begin
            state_next = S_IDLE;
            skip_next  = 3'd0;
            to_next    = '0;
            err_next   = 1'b1;
         end
         else begin
            to_next = to_reg + TO_WIDTH'(1);
         end
      end

      // Only transitions of the held bit produce events; repeats are silent.
      if (hit_any && do_make && !key_state_reg[hit_idx]) begin
         key_state_next[hit_idx] = 1'b1;
         ev_valid_next           = 1'b1;
         ev_key_next             = hit_idx;
         ev_pressed_next         = 1'b1;
      end
      if (hit_any && do_break && key_state_reg[hit_idx]) begin
         key_state_next[hit_idx] = 1'b0;
         ev_valid_next           = 1'b1;
         ev_key_next             = hit_idx;
         ev_pressed_next         = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         skip_reg       <= 3'd0;
         to_reg         <= '0;
         key_state_reg  <= '0;
         ev_valid_reg   <= 1'b0;
         ev_key_reg     <= 4'd0;
         ev_pressed_reg <= 1'b0;
         err_reg        <= 1'b0;
      end
      else begin
         state_reg      <= state_next;
         skip_reg       <= skip_next;
         to_reg         <= to_next;
         key_state_reg  <= key_state_next;
         ev_valid_reg   <= ev_valid_next;
         ev_key_reg     <= ev_key_next;
         ev_pressed_reg <= ev_pressed_next;
         err_reg        <= err_next;
      end
   end

   assign key_state   = key_state_reg;
   assign ev_valid    = ev_valid_reg;
   assign ev_key      = ev_key_reg;
   assign ev_pressed  = ev_pressed_reg;
   assign err_timeout = err_reg;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a byte-level reference model pushes expected
// events into a queue; a monitor pops them as the DUT reports events and also
// tracks the held-key bitmap every cycle.
module tb_ps2_key_decoder;

   localparam int T = 40;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       code_valid = 1'b0;
   logic [7:0] code_byte = 8'h00;
   logic [9:0] key_state;
   logic       ev_valid;
   logic [3:0] ev_key;
   logic       ev_pressed;
   logic       err_timeout;

   ps2_key_decoder #(.TIMEOUT_CYCLES(T), .TO_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .code_valid(code_valid), .code_byte(code_byte),
      .key_state(key_state), .ev_valid(ev_valid), .ev_key(ev_key),
      .ev_pressed(ev_pressed), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit is_to;
      int key;
      bit pressed;
      int due;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   // Reference model: prefix flags, remaining Pause bytes, idle gap length.
   bit         m_ext, m_brk;
   int         m_skip, m_idle;
   logic [9:0] m_ks = '0;

   function automatic int map_key(bit ext, logic [7:0] b);
      case ({ext, b})
         9'h01D: return 0;
         9'h01C: return 1;
         9'h01B: return 2;
         9'h023: return 3;
         9'h029: return 4;
         9'h175: return 5;
         9'h16B: return 6;
         9'h172: return 7;
         9'h174: return 8;
         9'h15A: return 9;
         default: return -1;
      endcase
   endfunction

   function automatic void model_reset();
      m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0; m_ks = '0;
   endfunction

   function automatic void model_key(bit ext, bit make, logic [7:0] b);
      int k;
      k = map_key(ext, b);
      if (k < 0) return;
      if (make != m_ks[k]) begin
         m_ks[k] = make;
         q.push_back('{is_to: 0, key: k, pressed: make, due: cyc + 1});
      end
   endfunction

   function automatic void model_step(bit v, logic [7:0] b);
      bit busy;
      busy = m_ext || m_brk || (m_skip > 0);
      if (!v) begin
         if (busy) begin
            m_idle++;
            if (m_idle == T) begin
               m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0;
               q.push_back('{is_to: 1, key: 0, pressed: 0, due: cyc + 1});
            end
         end
         return;
      end
      m_idle = 0;
      if (m_skip > 0) begin
         m_skip--;
      end
      else if (m_brk) begin
         model_key(m_ext, 0, b);
         m_ext = 0; m_brk = 0;
      end
      else if (m_ext) begin
         if (b == 8'hF0) m_brk = 1;
         else if (b != 8'hE0) begin
            model_key(1, 1, b);
            m_ext = 0;
         end
      end
      else begin
         case (b)
            8'hE0:   m_ext = 1;
            8'hF0:   m_brk = 1;
            8'hE1:   m_skip = 7;
            8'hAA:   m_ks = '0;
            default: model_key(0, 1, b);
         endcase
      end
   endfunction

   task automatic drive(bit v, logic [7:0] b);
      @(negedge clk);
      rst        = 1'b0;
      code_valid = v;
      code_byte  = b;
      model_step(v, b);
   endtask

   task automatic send(logic [7:0] b);
      drive(1'b1, b);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255));
   endtask

   task automatic check_ks(string name, logic [9:0] want);
      checks++;
      if (key_state !== want) begin
         errors++;
         $display("FAIL %s: key_state got %03h want %03h", name, key_state, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      code_valid = 1'b0;
      model_reset();
      @(negedge clk);
      checks++;
      if ({key_state, ev_valid, ev_key, ev_pressed, err_timeout} !== 17'd0) begin
         errors++;
         $display("FAIL reset: ks=%03h ev_valid=%0b ev_key=%0d pressed=%0b err=%0b want all 0",
                  key_state, ev_valid, ev_key, ev_pressed, err_timeout);
      end
      $display("reset: outputs ks=%03h ev_key=%0d", key_state, ev_key);
   endtask

   // Monitor: bitmap every cycle, event queue whenever the DUT reports one.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         checks++;
         if (key_state !== m_ks) begin
            errors++;
            $display("FAIL key_state @%0d: got %03h want %03h", cyc, key_state, m_ks);
         end
         if (ev_valid === 1'b1 && err_timeout === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL exclusive @%0d: ev_valid and err_timeout both high", cyc);
         end
         else if (ev_valid === 1'b1 || err_timeout === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected @%0d: ev_valid=%0b err=%0b key=%0d pressed=%0b want nothing",
                        cyc, ev_valid, err_timeout, ev_key, ev_pressed);
            end
            else begin
               e = q.pop_front();
               if (err_timeout !== e.is_to || e.due != cyc ||
                   (!e.is_to && (ev_key !== 4'(e.key) || ev_pressed !== e.pressed))) begin
                  errors++;
                  $display("FAIL event @%0d: got to=%0b key=%0d pressed=%0b want to=%0b key=%0d pressed=%0b due=%0d",
                           cyc, err_timeout, ev_key, ev_pressed, e.is_to, e.key, e.pressed, e.due);
               end
               else if (e.is_to) $display("event @%0d: timeout", cyc);
               else $display("event @%0d: key=%0d pressed=%0b ks=%03h", cyc, ev_key, ev_pressed, key_state);
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by a randomized byte stream.
   initial begin
      logic [7:0] pool [14];
      pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29, 8'h75, 8'h6B,
               8'h72, 8'h74, 8'h5A, 8'hE0, 8'hF0, 8'hE1, 8'hAA};
      model_reset();
      do_reset();

      send(8'h1D); idle(2); check_ks("make_w", 10'h001);
      send(8'hF0); send(8'h1D); idle(2); check_ks("break_w", 10'h000);

      for (int i = 0; i < 3; i++) begin send(8'hE0); send(8'h75); idle(1); end
      check_ks("ext_repeat", 10'h020);
      send(8'hE0); send(8'hF0); send(8'h75); idle(2); check_ks("ext_break", 10'h000);

      send(8'h1C); send(8'h23); send(8'h15); idle(2); check_ks("b2b", 10'h00A);
      send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23); idle(1);

      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h29); idle(2); check_ks("pause", 10'h010);
      send(8'hF0); send(8'h29); idle(1);

      send(8'hF0); idle(T); send(8'h1B); idle(2); check_ks("timeout_make", 10'h004);
      send(8'hF0); idle(T - 1); send(8'h1B); idle(2); check_ks("expiry_byte", 10'h000);

      send(8'h1D); send(8'hE0); send(8'h75); idle(1); check_ks("hold", 10'h021);
      send(8'hAA); idle(2); check_ks("bat", 10'h000);
      send(8'h1D); send(8'hE0); do_reset();
      send(8'h75); idle(2); check_ks("post_reset", 10'h000);

      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 19);
         if (r < 14) send(pool[r]);
         else send(8'($urandom_range(0, 255)));
         r = $urandom_range(0, 19);
         if (r == 0)      idle(T - 1);
         else if (r == 1) idle(T + $urandom_range(0, 3));
         else if (r < 8)  idle($urandom_range(1, 3));
      end

      idle(T + 5);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected events never seen, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Sequences the byte stream from the PS/2 receiver into per-key make/break events and a held-key bitmap for both players' game controls.
- Tracks the E0 (extended) and F0 (break) prefixes, skips the Pause (E1) sequence, and recovers from dropped bytes by timeout.
- Sits between the PS/2 receiver and the game logic; all processing is single-clock and synchronous.

Parameters:
- TIMEOUT_CYCLES, 2000000: clk cycles a prefix state waits for its next byte before aborting (20 ms at 100 MHz).
- TO_WIDTH, 21: width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- code_valid  in  1  one-cycle pulse: new byte from the receiver.
- code_byte  in  8  scan-code byte; sampled only when code_valid=1.
- key_state  out  10  held-key bitmap; bit=1 means the key is down.
- ev_valid  out  1  one-cycle pulse: key event.
- ev_key  out  4  key index of the event (0..9).
- ev_pressed  out  1  1=make, 0=break; valid with ev_valid.
- err_timeout  out  1  one-cycle pulse: a prefix sequence was aborted.

Behaviour:
- Single clock and reset: clk; reset is synchronous, active-high (rst).
- Reset: key_state=0, ev_valid=0, ev_key=0, ev_pressed=0, err_timeout=0, FSM=IDLE, timeout counter=0, skip counter=0. Reset mid-sequence discards any partial prefix.
- Key map (index: code):
  - Player 1: 0:1D (W), 1:1C (A), 2:1B (S), 3:23 (D), 4:29 (Space).
  - Player 2, extended: 5:E0 75 (Up), 6:E0 6B (Left), 7:E0 72 (Down), 8:E0 74 (Right), 9:E0 5A (keypad Enter).
  - Non-extended codes match only indices 0-4; extended codes match only indices 5-9. Unmapped codes are dropped silently.
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. All transitions occur on code_valid only, except the timeout transition.
  - IDLE: E0->EXT; F0->BRK; E1->SKIP with skip counter=7; AA->clear key_state, stay IDLE; any other byte = make lookup (non-extended), stay IDLE.
  - EXT: F0->EXT_BRK; E0->stay EXT; any other byte = make lookup (extended)->IDLE.
  - BRK: any byte = break lookup (non-extended)->IDLE.
  - EXT_BRK: any byte = break lookup (extended)->IDLE.
  - SKIP: each byte decrements the skip counter; when it reaches 0, go to IDLE. No events are emitted.
- Make on a mapped key:
  - key_state bit already 1 (typematic repeat): no event.
  - Otherwise: set the bit, and pulse ev_valid with ev_pressed=1.
- Break on a mapped key:
  - Bit is 1: clear it, and pulse ev_valid with ev_pressed=0.
  - Bit is 0: no event.
- Latency: ev_valid and the key_state update appear on the clk edge after the cycle in which code_valid carries the final byte (1 cycle). ev_key and ev_pressed hold their values until the next event.
- Back-to-back: code_valid may be asserted on consecutive cycles; every byte is processed with no drop.
- Timeout: the counter runs in EXT, BRK, EXT_BRK and SKIP, and clears on every code_valid and on entry to IDLE. When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse err_timeout, no key event.
- Simultaneous: if code_valid and timeout expiry occur in the same cycle, the byte wins — it is processed in the current state and there is no err_timeout.
- ev_valid and err_timeout are never asserted in the same cycle.

Test Plan:
- Make/break: bytes 1D, then F0 1D -> ev(key0, pressed=1), key_state=0x001; then ev(key0, pressed=0), key_state=0x000.
- Extended and repeat: E0 75 sent three times, then E0 F0 75 -> exactly one make event (key5), key_state bit5=1; then one break event, bit5=0.
- Back-to-back and unmapped: 1C, 23, 15, each on consecutive cycles with code_valid held high -> events key1 and key3 on consecutive cycles; 15 is ignored; key_state=0x00A.
- Pause skip: E1 14 77 E1 F0 14 F0 77, then 29 -> no events for the first 8 bytes; then ev(key4, pressed=1).
- Timeout: F0 followed by a TIMEOUT_CYCLES idle gap -> err_timeout pulses once, FSM returns to IDLE; a following 1B -> make event (key2), not a break. Repeat with the byte arriving exactly in the expiry cycle -> break lookup, no err_timeout.
- Reset and BAT: hold W and Up (key_state=0x021) -> AA clears key_state to 0 with no events; send E0, then assert rst -> all outputs 0; then 75 -> treated as a non-extended, unmapped byte and ignored.
